// File: rtl/audio_sample_streamer_if.sv
// Write-side bus between the sample streamer and the Audio_Controller.
// The streamer presents the FIFO head on the two channel words and strobes
// write_audio_out whenever the controller signals it can take a frame.
interface audio_sample_streamer_if #(
  parameter int OUT_W = 32
);
  logic             audio_out_allowed;
  logic [OUT_W-1:0] left_channel_audio_out;
  logic [OUT_W-1:0] right_channel_audio_out;
  logic             write_audio_out;

  // Streamer side: drives the frame and strobe, listens to the ready level.
  modport master (
    input  audio_out_allowed,
    output left_channel_audio_out,
    output right_channel_audio_out,
    output write_audio_out
  );

  // Controller side: drives the ready level, consumes frame and strobe.
  modport slave (
    output audio_out_allowed,
    input  left_channel_audio_out,
    input  right_channel_audio_out,
    input  write_audio_out
  );
endinterface

// File: rtl/audio_sample_streamer.sv
// Samples the synth waveform at a programmable rate, converts each sample to
// the DAC word format, buffers frames in a small first-word-fall-through FIFO
// and feeds the Audio_Controller write handshake. Overflow (tick while full)
// and underrun (controller ready while empty, after the first write) are
// reported as sticky flags cleared only by reset.
module audio_sample_streamer #(
  parameter int IN_W     = 7,
  parameter int OUT_W    = 32,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 8,
  parameter int DIV      = 1042,
  parameter int MODE     = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [IN_W-1:0]          sample_l,
  input  logic [IN_W-1:0]          sample_r,
  input  logic                     enable,
  input  logic                     mute,
  audio_sample_streamer_if.master  aud,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic                     underrun
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DIV);
  localparam int PAD = OUT_W - IN_W;

  localparam logic [IN_W-1:0] MIDSCALE   = IN_W'(1) << (IN_W - 1);
  localparam logic [AW:0]     FULL_LEVEL = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0]   DIV_LAST   = CW'(DIV - 1);

  // Mute substitution followed by the DAC word mapping. Flipping the MSB of
  // offset-binary gives two's complement, which is then left-justified.
  function automatic logic [OUT_W-1:0] convert(input logic [IN_W-1:0] raw,
                                               input logic            m);
    logic [IN_W-1:0] u;
    u = m ? MIDSCALE : raw;
    if (MODE == 0) begin
      convert = OUT_W'(u);
    end else begin
      convert = OUT_W'(u ^ MIDSCALE) << PAD;
    end
  endfunction

  // ---------------------------------------------------------------------
  // Sample-rate divider
  // ---------------------------------------------------------------------
  logic [CW-1:0] div_cnt_reg;
  logic          tick;

  assign tick = enable && (div_cnt_reg == DIV_LAST);

  // Free-running 0..DIV-1 counter, parked at zero while disabled.
  always_ff @(posedge clock) begin
    if (reset || !enable || tick) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Frame conversion
  // ---------------------------------------------------------------------
  logic [OUT_W-1:0] frame_l;
  logic [OUT_W-1:0] frame_r;

  assign frame_l = convert(sample_l, mute);

  generate
    if (CHANNELS == 1) begin : g_mono
      assign frame_r = frame_l;
    end else begin : g_stereo
      assign frame_r = convert(sample_r, mute);
    end
  endgenerate

  // ---------------------------------------------------------------------
  // FIFO storage and control
  // ---------------------------------------------------------------------
  logic [OUT_W-1:0] mem_l [DEPTH];
  logic [OUT_W-1:0] mem_r [DEPTH];

  logic [AW-1:0]    wr_ptr_reg,  wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg,  rd_ptr_next;
  logic [AW:0]      level_reg,   level_next;
  logic [OUT_W-1:0] head_l_reg;
  logic [OUT_W-1:0] head_r_reg;
  logic             first_write_reg;
  logic             overflow_reg;
  logic             underrun_reg;

  logic empty;
  logic full;
  logic pop;
  logic push;
  logic bypass;

  assign empty = (level_reg == '0);
  assign full  = (level_reg == FULL_LEVEL);
  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign pop   = !empty && aud.audio_out_allowed;
  assign push  = tick && (!full || pop);
  // The frame being written is also the next head: forward it directly.
  assign bypass = push && (wr_ptr_reg == rd_ptr_next);

  // Pointer and occupancy update for the current push/pop combination.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
    case ({push, pop})
      2'b10:   level_next = level_reg + 1'b1;
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
  end

  // Frame storage; no reset so the arrays map onto block RAM.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_l[wr_ptr_reg] <= frame_l;
      mem_r[wr_ptr_reg] <= frame_r;
    end
  end

  // Registered head: reads the next head entry (or the incoming frame) and
  // holds its last value once the FIFO runs empty.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_l_reg <= '0;
      head_r_reg <= '0;
    end else if (level_next != '0) begin
      head_l_reg <= bypass ? frame_l : mem_l[rd_ptr_next];
      head_r_reg <= bypass ? frame_r : mem_r[rd_ptr_next];
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
    end
  end

  // Sticky status: dropped frames, starvation after the first write.
  always_ff @(posedge clock) begin
    if (reset) begin
      first_write_reg <= 1'b0;
      overflow_reg    <= 1'b0;
      underrun_reg    <= 1'b0;
    end else begin
      if (pop) begin
        first_write_reg <= 1'b1;
      end
      if (tick && full && !pop) begin
        overflow_reg <= 1'b1;
      end
      if (aud.audio_out_allowed && empty && first_write_reg) begin
        underrun_reg <= 1'b1;
      end
    end
  end

  assign aud.left_channel_audio_out  = head_l_reg;
  assign aud.right_channel_audio_out = head_r_reg;
  assign aud.write_audio_out         = pop;
  assign fifo_level                  = level_reg;
  assign overflow                    = overflow_reg;
  assign underrun                    = underrun_reg;

endmodule

// File: tb/tb_audio_sample_streamer.sv
// Directed bench for audio_sample_streamer. Three instances share the input
// stimulus: A (MODE 1, stereo, DEPTH 4), B (MODE 0, stereo, DEPTH 8) and
// C (MODE 0, mono, DEPTH 4), all with DIV = 4.
module tb_audio_sample_streamer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] sample_l = '0;
  logic [6:0] sample_r = '0;
  logic       enable = 1'b0;
  logic       mute = 1'b0;
  logic       allowed = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  audio_sample_streamer_if #(.OUT_W(32)) if_a ();
  audio_sample_streamer_if #(.OUT_W(32)) if_b ();
  audio_sample_streamer_if #(.OUT_W(32)) if_c ();

  assign if_a.audio_out_allowed = allowed;
  assign if_b.audio_out_allowed = allowed;
  assign if_c.audio_out_allowed = allowed;

  logic [2:0] level_a;
  logic [3:0] level_b;
  logic [2:0] level_c;
  logic       ovf_a, unr_a, ovf_b, unr_b, ovf_c, unr_c;

  audio_sample_streamer #(
    .IN_W(7), .OUT_W(32), .CHANNELS(2), .DEPTH(4), .DIV(4), .MODE(1)
  ) dut_a (
    .clock(clock), .reset(reset), .sample_l(sample_l), .sample_r(sample_r),
    .enable(enable), .mute(mute), .aud(if_a), .fifo_level(level_a),
    .overflow(ovf_a), .underrun(unr_a)
  );

  audio_sample_streamer #(
    .IN_W(7), .OUT_W(32), .CHANNELS(2), .DEPTH(8), .DIV(4), .MODE(0)
  ) dut_b (
    .clock(clock), .reset(reset), .sample_l(sample_l), .sample_r(sample_r),
    .enable(enable), .mute(mute), .aud(if_b), .fifo_level(level_b),
    .overflow(ovf_b), .underrun(unr_b)
  );

  audio_sample_streamer #(
    .IN_W(7), .OUT_W(32), .CHANNELS(1), .DEPTH(4), .DIV(4), .MODE(0)
  ) dut_c (
    .clock(clock), .reset(reset), .sample_l(sample_l), .sample_r(sample_r),
    .enable(enable), .mute(mute), .aud(if_c), .fifo_level(level_c),
    .overflow(ovf_c), .underrun(unr_c)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    allowed = 1'b0;
    enable  = 1'b0;
    do_reset();
    checks++; if (level_a !== 3'd0) begin failures++; $display("FAIL reset_level: got %0d expected 0", level_a); end
    checks++; if (if_a.write_audio_out !== 1'b0) begin failures++; $display("FAIL reset_strobe: got %b expected 0", if_a.write_audio_out); end
    checks++; if (if_a.left_channel_audio_out !== 32'h0) begin failures++; $display("FAIL reset_left: got %h expected 00000000", if_a.left_channel_audio_out); end
    checks++; if (if_a.right_channel_audio_out !== 32'h0) begin failures++; $display("FAIL reset_right: got %h expected 00000000", if_a.right_channel_audio_out); end
    checks++; if (ovf_a !== 1'b0 || unr_a !== 1'b0) begin failures++; $display("FAIL reset_flags: got ovf=%b unr=%b expected 0 0", ovf_a, unr_a); end
    $display("test_reset: level=%0d strobe=%b", level_a, if_a.write_audio_out);
  endtask

  task automatic test_mode1();
    logic [6:0]  vin [3] = '{7'h7F, 7'h00, 7'h40};
    logic [31:0] vexp[3] = '{32'h7E000000, 32'h80000000, 32'h00000000};
    int pulses;
    mute = 1'b0; enable = 1'b0; allowed = 1'b1;
    do_reset();
    enable = 1'b1;
    sample_r = 7'h00;
    for (int i = 0; i < 3; i++) begin
      sample_l = vin[i];
      pulses = 0;
      for (int c = 0; c < 4; c++) begin
        step(1);
        if (if_a.write_audio_out === 1'b1) pulses++;
      end
      $display("test_mode1: in=%h left=%h right=%h strobe=%b", vin[i],
               if_a.left_channel_audio_out, if_a.right_channel_audio_out, if_a.write_audio_out);
      checks++; if (pulses !== 1) begin failures++; $display("FAIL mode1_pulses[%0d]: got %0d expected 1", i, pulses); end
      checks++; if (if_a.write_audio_out !== 1'b1) begin failures++; $display("FAIL mode1_strobe[%0d]: got %b expected 1", i, if_a.write_audio_out); end
      checks++; if (if_a.left_channel_audio_out !== vexp[i]) begin failures++; $display("FAIL mode1_left[%0d]: got %h expected %h", i, if_a.left_channel_audio_out, vexp[i]); end
      checks++; if (if_a.right_channel_audio_out !== 32'h80000000) begin failures++; $display("FAIL mode1_right[%0d]: got %h expected 80000000", i, if_a.right_channel_audio_out); end
    end
  endtask

  task automatic test_mode0_channels();
    enable = 1'b0; allowed = 1'b1; mute = 1'b0;
    do_reset();
    sample_l = 7'h55; sample_r = 7'h2A; enable = 1'b1;
    step(4);
    $display("test_mode0: b=%h/%h c=%h/%h", if_b.left_channel_audio_out, if_b.right_channel_audio_out,
             if_c.left_channel_audio_out, if_c.right_channel_audio_out);
    checks++; if (if_b.write_audio_out !== 1'b1) begin failures++; $display("FAIL mode0_strobe: got %b expected 1", if_b.write_audio_out); end
    checks++; if (if_b.left_channel_audio_out !== 32'h00000055) begin failures++; $display("FAIL mode0_left: got %h expected 00000055", if_b.left_channel_audio_out); end
    checks++; if (if_b.right_channel_audio_out !== 32'h0000002A) begin failures++; $display("FAIL mode0_right: got %h expected 0000002a", if_b.right_channel_audio_out); end
    checks++; if (if_c.left_channel_audio_out !== 32'h00000055) begin failures++; $display("FAIL mono_left: got %h expected 00000055", if_c.left_channel_audio_out); end
    checks++; if (if_c.right_channel_audio_out !== 32'h00000055) begin failures++; $display("FAIL mono_right: got %h expected 00000055", if_c.right_channel_audio_out); end
  endtask

  task automatic test_mute();
    enable = 1'b0; allowed = 1'b1;
    do_reset();
    mute = 1'b1; sample_l = 7'h7F; sample_r = 7'h00; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(4);
      $display("test_mute: write %0d left=%h right=%h", i, if_a.left_channel_audio_out, if_a.right_channel_audio_out);
      checks++; if (if_a.write_audio_out !== 1'b1) begin failures++; $display("FAIL mute_strobe[%0d]: got %b expected 1", i, if_a.write_audio_out); end
      checks++; if (if_a.left_channel_audio_out !== 32'h0) begin failures++; $display("FAIL mute_left[%0d]: got %h expected 00000000", i, if_a.left_channel_audio_out); end
      checks++; if (if_a.right_channel_audio_out !== 32'h0) begin failures++; $display("FAIL mute_right[%0d]: got %h expected 00000000", i, if_a.right_channel_audio_out); end
    end
    checks++; if (if_b.left_channel_audio_out !== 32'h00000040) begin failures++; $display("FAIL mute_mode0: got %h expected 00000040", if_b.left_channel_audio_out); end
    mute = 1'b0;
  endtask

  task automatic test_overflow_drain();
    logic [2:0]  lvl_tab [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
    logic        ovf_tab [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] drain_tab[4] = '{32'h82000000, 32'h84000000, 32'h86000000, 32'h88000000};
    enable = 1'b0; allowed = 1'b0;
    do_reset();
    sample_r = 7'h7F; enable = 1'b1;
    for (int n = 0; n < 6; n++) begin
      sample_l = 7'(n + 1);
      step(4);
      $display("test_overflow: tick %0d level=%0d overflow=%b", n + 1, level_a, ovf_a);
      checks++; if (level_a !== lvl_tab[n]) begin failures++; $display("FAIL ovf_level[%0d]: got %0d expected %0d", n, level_a, lvl_tab[n]); end
      checks++; if (ovf_a !== ovf_tab[n]) begin failures++; $display("FAIL ovf_flag[%0d]: got %b expected %b", n, ovf_a, ovf_tab[n]); end
    end
    enable = 1'b0; allowed = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      $display("test_drain: pop %0d left=%h right=%h strobe=%b", k, if_a.left_channel_audio_out,
               if_a.right_channel_audio_out, if_a.write_audio_out);
      checks++; if (if_a.write_audio_out !== 1'b1) begin failures++; $display("FAIL drain_strobe[%0d]: got %b expected 1", k, if_a.write_audio_out); end
      checks++; if (if_a.left_channel_audio_out !== drain_tab[k]) begin failures++; $display("FAIL drain_left[%0d]: got %h expected %h", k, if_a.left_channel_audio_out, drain_tab[k]); end
      checks++; if (if_a.right_channel_audio_out !== 32'h7E000000) begin failures++; $display("FAIL drain_right[%0d]: got %h expected 7e000000", k, if_a.right_channel_audio_out); end
      step(1);
    end
    checks++; if (if_a.write_audio_out !== 1'b0) begin failures++; $display("FAIL drain_empty_strobe: got %b expected 0", if_a.write_audio_out); end
    checks++; if (level_a !== 3'd0) begin failures++; $display("FAIL drain_empty_level: got %0d expected 0", level_a); end
    checks++; if (if_a.left_channel_audio_out !== 32'h88000000) begin failures++; $display("FAIL drain_hold: got %h expected 88000000", if_a.left_channel_audio_out); end
    checks++; if (unr_a !== 1'b0) begin failures++; $display("FAIL underrun_early: got %b expected 0", unr_a); end
    step(1);
    checks++; if (unr_a !== 1'b1) begin failures++; $display("FAIL underrun_set: got %b expected 1", unr_a); end
    allowed = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_tab[4] = '{32'h84000000, 32'h86000000, 32'h88000000, 32'h8A000000};
    enable = 1'b0; allowed = 1'b0;
    do_reset();
    sample_r = 7'h7F; enable = 1'b1;
    for (int n = 0; n < 4; n++) begin
      sample_l = 7'(n + 1);
      step(4);
    end
    checks++; if (level_a !== 3'd4) begin failures++; $display("FAIL full_level: got %0d expected 4", level_a); end
    sample_l = 7'h05;
    step(3);
    allowed = 1'b1;
    #1;
    checks++; if (if_a.write_audio_out !== 1'b1) begin failures++; $display("FAIL full_pop_strobe: got %b expected 1", if_a.write_audio_out); end
    step(1);
    $display("test_full_push_pop: level=%0d overflow=%b head=%h", level_a, ovf_a, if_a.left_channel_audio_out);
    checks++; if (level_a !== 3'd4) begin failures++; $display("FAIL pushpop_level: got %0d expected 4", level_a); end
    checks++; if (ovf_a !== 1'b0) begin failures++; $display("FAIL pushpop_overflow: got %b expected 0", ovf_a); end
    enable = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      $display("test_full_push_pop: pop %0d left=%h", k, if_a.left_channel_audio_out);
      checks++; if (if_a.write_audio_out !== 1'b1) begin failures++; $display("FAIL pushpop_strobe[%0d]: got %b expected 1", k, if_a.write_audio_out); end
      checks++; if (if_a.left_channel_audio_out !== exp_tab[k]) begin failures++; $display("FAIL pushpop_left[%0d]: got %h expected %h", k, if_a.left_channel_audio_out, exp_tab[k]); end
      step(1);
    end
    checks++; if (level_a !== 3'd0) begin failures++; $display("FAIL pushpop_drained: got %0d expected 0", level_a); end
    allowed = 1'b0;
  endtask

  task automatic test_reset_midstream();
    enable = 1'b0; allowed = 1'b0;
    do_reset();
    sample_l = 7'h7F; sample_r = 7'h00; enable = 1'b1;
    step(20);
    enable = 1'b0; allowed = 1'b1;
    step(1);
    allowed = 1'b0;
    #1;
    checks++; if (level_a !== 3'd3) begin failures++; $display("FAIL mid_level_pre: got %0d expected 3", level_a); end
    checks++; if (ovf_a !== 1'b1) begin failures++; $display("FAIL mid_ovf_pre: got %b expected 1", ovf_a); end
    reset = 1'b1; allowed = 1'b1; enable = 1'b1;
    step(1);
    $display("test_reset_midstream: level=%0d left=%h strobe=%b", level_a, if_a.left_channel_audio_out, if_a.write_audio_out);
    checks++; if (level_a !== 3'd0) begin failures++; $display("FAIL mid_level: got %0d expected 0", level_a); end
    checks++; if (if_a.left_channel_audio_out !== 32'h0 || if_a.right_channel_audio_out !== 32'h0) begin failures++; $display("FAIL mid_outputs: got %h/%h expected 0/0", if_a.left_channel_audio_out, if_a.right_channel_audio_out); end
    checks++; if (if_a.write_audio_out !== 1'b0) begin failures++; $display("FAIL mid_strobe: got %b expected 0", if_a.write_audio_out); end
    checks++; if (ovf_a !== 1'b0 || unr_a !== 1'b0) begin failures++; $display("FAIL mid_flags: got ovf=%b unr=%b expected 0 0", ovf_a, unr_a); end
    reset = 1'b0;
    sample_l = 7'h00;
    step(3);
    checks++; if (level_a !== 3'd0 || if_a.write_audio_out !== 1'b0) begin failures++; $display("FAIL mid_early_tick: got level=%0d strobe=%b expected 0 0", level_a, if_a.write_audio_out); end
    checks++; if (unr_a !== 1'b0) begin failures++; $display("FAIL mid_firstwrite_cleared: got %b expected 0", unr_a); end
    step(1);
    $display("test_reset_midstream: first tick left=%h strobe=%b", if_a.left_channel_audio_out, if_a.write_audio_out);
    checks++; if (if_a.write_audio_out !== 1'b1) begin failures++; $display("FAIL mid_first_tick: got %b expected 1", if_a.write_audio_out); end
    checks++; if (if_a.left_channel_audio_out !== 32'h80000000) begin failures++; $display("FAIL mid_first_left: got %h expected 80000000", if_a.left_channel_audio_out); end
    allowed = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mode1();
    test_mode0_channels();
    test_mute();
    test_overflow_drain();
    test_full_push_pop();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
